// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Holds the prediction records issued by fetch in a small FIFO. When EX
//   resolves a branch or jump, it compares the actual outcome with the
//   record at the head, trains the predictor, and on a mispredict
//   redirects fetch and flushes the younger stages.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   pred_valid_i/pc/taken/target  prediction record from fetch
//   pred_ready_o                  record accepted (FIFO not full, combinational)
//   ex_valid_i, ex_jump_i,
//   ex_jalr_i, ex_funct3_i        EX holds a branch/jump and its kind
//   rs1_i, rs2_i, imm_i           EX operands
//   upd_*_o                       predictor training packet (registered)
//   redirect_o, redirect_pc_o,
//   flush_o                       fetch redirect and younger-stage flush
//   branch_cnt_o, mispred_cnt_o   saturating statistics counters
//   fifo_err_o                    EX resolved with no record queued
module branch_resolve_unit #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pred_valid_i,
    input  logic [31:0]      pred_pc_i,
    input  logic             pred_taken_i,
    input  logic [31:0]      pred_target_i,
    output logic             pred_ready_o,
    input  logic             ex_valid_i,
    input  logic             ex_jump_i,
    input  logic             ex_jalr_i,
    input  logic [2:0]       ex_funct3_i,
    input  logic [31:0]      rs1_i,
    input  logic [31:0]      rs2_i,
    input  logic [31:0]      imm_i,
    output logic             upd_valid_o,
    output logic [31:0]      upd_pc_o,
    output logic             upd_taken_o,
    output logic [31:0]      upd_target_o,
    output logic             redirect_o,
    output logic [31:0]      redirect_pc_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o,
    output logic             fifo_err_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [31:0]      pc_mem     [DEPTH];
    logic             taken_mem  [DEPTH];
    logic [31:0]      target_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    logic             full;
    logic             empty;
    logic             resolve;
    logic             push;
    logic             actual_taken;
    logic [31:0]      target;
    logic             mispred;
    logic [31:0]      head_pc;
    logic             head_taken;
    logic [31:0]      head_target;

    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign pred_ready_o = ~full;

    always_comb begin
        head_pc      = pc_mem[rd_ptr];
        head_taken   = taken_mem[rd_ptr];
        head_target  = target_mem[rd_ptr];
        resolve      = ex_valid_i & ~empty;

        actual_taken = 1'b0;
        if (ex_jump_i) begin
            actual_taken = 1'b1;
        end else begin
            case (ex_funct3_i)
                3'b000:  actual_taken = (rs1_i == rs2_i);
                3'b001:  actual_taken = (rs1_i != rs2_i);
                3'b100:  actual_taken = ($signed(rs1_i) <  $signed(rs2_i));
                3'b101:  actual_taken = ($signed(rs1_i) >= $signed(rs2_i));
                3'b110:  actual_taken = (rs1_i <  rs2_i);
                3'b111:  actual_taken = (rs1_i >= rs2_i);
                default: actual_taken = 1'b0;
            endcase
        end

        if (ex_jalr_i) begin
            target = (rs1_i + imm_i) & ~32'h1;
        end else begin
            target = head_pc + imm_i;
        end

        mispred = resolve & ((actual_taken != head_taken) |
                             (actual_taken & (target != head_target)));

        // A full FIFO refuses pushes even when popping; a mispredict drops them.
        push = pred_valid_i & ~full & ~mispred;
    end

    // Record storage needs no reset: occupancy alone decides validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr]     <= pred_pc_i;
            taken_mem[wr_ptr]  <= pred_taken_i;
            target_mem[wr_ptr] <= pred_target_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (mispred) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (resolve) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, resolve})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            upd_valid_o   <= 1'b0;
            upd_pc_o      <= '0;
            upd_taken_o   <= 1'b0;
            upd_target_o  <= '0;
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
            flush_o       <= 1'b0;
            branch_cnt_o  <= '0;
            mispred_cnt_o <= '0;
            fifo_err_o    <= 1'b0;
        end else begin
            upd_valid_o <= resolve;
            redirect_o  <= mispred;
            flush_o     <= mispred;
            fifo_err_o  <= ex_valid_i & empty;
            if (resolve) begin
                upd_pc_o     <= head_pc;
                upd_taken_o  <= actual_taken;
                upd_target_o <= target;
                if (branch_cnt_o != '1) begin
                    branch_cnt_o <= branch_cnt_o + 1'b1;
                end
            end
            if (mispred) begin
                redirect_pc_o <= actual_taken ? target : head_pc + 32'd4;
                if (mispred_cnt_o != '1) begin
                    mispred_cnt_o <= mispred_cnt_o + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: a reference model predicts the
// registered outputs for every cycle and queues them; each expectation is
// popped and compared one cycle later, after the clock edge.
module tb_branch_resolve_unit;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             pred_valid_i;
    logic [31:0]      pred_pc_i;
    logic             pred_taken_i;
    logic [31:0]      pred_target_i;
    logic             pred_ready_o;
    logic             ex_valid_i;
    logic             ex_jump_i;
    logic             ex_jalr_i;
    logic [2:0]       ex_funct3_i;
    logic [31:0]      rs1_i;
    logic [31:0]      rs2_i;
    logic [31:0]      imm_i;
    logic             upd_valid_o;
    logic [31:0]      upd_pc_o;
    logic             upd_taken_o;
    logic [31:0]      upd_target_o;
    logic             redirect_o;
    logic [31:0]      redirect_pc_o;
    logic             flush_o;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] mispred_cnt_o;
    logic             fifo_err_o;

    branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .pred_valid_i(pred_valid_i), .pred_pc_i(pred_pc_i),
        .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
        .pred_ready_o(pred_ready_o),
        .ex_valid_i(ex_valid_i), .ex_jump_i(ex_jump_i), .ex_jalr_i(ex_jalr_i),
        .ex_funct3_i(ex_funct3_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
        .upd_valid_o(upd_valid_o), .upd_pc_o(upd_pc_o),
        .upd_taken_o(upd_taken_o), .upd_target_o(upd_target_o),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .flush_o(flush_o),
        .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o),
        .fifo_err_o(fifo_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } rec_t;

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        utk;
        logic [31:0] utg;
        logic        rd;
        logic [31:0] rpc;
        logic        fl;
        logic        er;
        logic [31:0] bc;
        logic [31:0] mc;
        logic        rdy;
    } exp_t;

    rec_t mq[$];
    exp_t sb[$];

    logic [31:0] m_upc, m_utg, m_rpc, m_bc, m_mc;
    logic        m_utk;

    int checks = 0;
    int errors = 0;

    // stimulus for the next cycle
    logic        s_pv, s_ptk, s_exv, s_jump, s_jalr;
    logic [31:0] s_ppc, s_ptg, s_rs1, s_rs2, s_imm;
    logic [2:0]  s_f3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic model_taken(input logic jump, input logic [2:0] f3,
                                         input logic [31:0] a, input logic [31:0] b);
        int sa, sb2;
        sa  = int'(a);
        sb2 = int'(b);
        if (jump) return 1'b1;
        if (f3 == 3'b000) return a == b;
        if (f3 == 3'b001) return a != b;
        if (f3 == 3'b100) return sa < sb2;
        if (f3 == 3'b101) return !(sa < sb2);
        if (f3 == 3'b110) return a < b;
        if (f3 == 3'b111) return !(a < b);
        return 1'b0;
    endfunction

    task automatic set_idle();
        s_pv = 0; s_ppc = 0; s_ptk = 0; s_ptg = 0;
        s_exv = 0; s_jump = 0; s_jalr = 0; s_f3 = 0;
        s_rs1 = 0; s_rs2 = 0; s_imm = 0;
    endtask

    task automatic model_reset();
        mq.delete();
        sb.delete();
        m_upc = 0; m_utk = 0; m_utg = 0; m_rpc = 0; m_bc = 0; m_mc = 0;
    endtask

    task automatic step();
        exp_t e, g;
        rec_t h, r;
        logic full_before, mis, at;
        logic [31:0] tg;
        @(negedge clk_i);
        pred_valid_i = s_pv; pred_pc_i = s_ppc; pred_taken_i = s_ptk; pred_target_i = s_ptg;
        ex_valid_i = s_exv; ex_jump_i = s_jump; ex_jalr_i = s_jalr; ex_funct3_i = s_f3;
        rs1_i = s_rs1; rs2_i = s_rs2; imm_i = s_imm;

        e.uv = 0; e.rd = 0; e.fl = 0; e.er = 0;
        full_before = (mq.size() == DEPTH);
        mis = 0;
        if (s_exv && mq.size() == 0) begin
            e.er = 1;
        end else if (s_exv) begin
            h  = mq.pop_front();
            at = model_taken(s_jump, s_f3, s_rs1, s_rs2);
            tg = s_jalr ? ((s_rs1 + s_imm) & 32'hFFFF_FFFE) : h.pc + s_imm;
            mis = (at != h.taken) || (at && tg != h.target);
            e.uv = 1;
            m_upc = h.pc; m_utk = at; m_utg = tg;
            if (m_bc != 32'h0000_FFFF) m_bc = m_bc + 1;
            if (mis) begin
                mq.delete();
                e.rd = 1; e.fl = 1;
                m_rpc = at ? tg : h.pc + 4;
                if (m_mc != 32'h0000_FFFF) m_mc = m_mc + 1;
            end
        end
        if (s_pv && !full_before && !mis) begin
            r.pc = s_ppc; r.taken = s_ptk; r.target = s_ptg;
            mq.push_back(r);
        end
        e.upc = m_upc; e.utk = m_utk; e.utg = m_utg; e.rpc = m_rpc;
        e.bc = m_bc; e.mc = m_mc; e.rdy = (mq.size() < DEPTH);
        sb.push_back(e);

        @(posedge clk_i);
        #1;
        g = sb.pop_front();
        check("upd_valid",   32'(upd_valid_o),   32'(g.uv));
        check("upd_pc",      upd_pc_o,           g.upc);
        check("upd_taken",   32'(upd_taken_o),   32'(g.utk));
        check("upd_target",  upd_target_o,       g.utg);
        check("redirect",    32'(redirect_o),    32'(g.rd));
        check("redirect_pc", redirect_pc_o,      g.rpc);
        check("flush",       32'(flush_o),       32'(g.fl));
        check("fifo_err",    32'(fifo_err_o),    32'(g.er));
        check("branch_cnt",  32'(branch_cnt_o),  g.bc);
        check("mispred_cnt", 32'(mispred_cnt_o), g.mc);
        check("pred_ready",  32'(pred_ready_o),  32'(g.rdy));
    endtask

    task automatic push_rec(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        set_idle();
        s_pv = 1; s_ppc = pc; s_ptk = tk; s_ptg = tg;
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_upd_valid"},   32'(upd_valid_o),   0);
        check({tag, "_upd_pc"},      upd_pc_o,           0);
        check({tag, "_upd_target"},  upd_target_o,       0);
        check({tag, "_redirect"},    32'(redirect_o),    0);
        check({tag, "_redirect_pc"}, redirect_pc_o,      0);
        check({tag, "_flush"},       32'(flush_o),       0);
        check({tag, "_branch_cnt"},  32'(branch_cnt_o),  0);
        check({tag, "_mispred_cnt"}, 32'(mispred_cnt_o), 0);
        check({tag, "_fifo_err"},    32'(fifo_err_o),    0);
        check({tag, "_pred_ready"},  32'(pred_ready_o),  1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        set_idle();
        pred_valid_i = 0; pred_pc_i = 0; pred_taken_i = 0; pred_target_i = 0;
        ex_valid_i = 0; ex_jump_i = 0; ex_jalr_i = 0; ex_funct3_i = 0;
        rs1_i = 0; rs2_i = 0; imm_i = 0;
        rst_ni = 0;
        model_reset();
        #23;
        check_all_zero("reset");
        @(negedge clk_i);
        rst_ni = 1;

        // correct not-taken BEQ
        push_rec(32'h100, 0, 0);
        set_idle(); s_exv = 1; s_f3 = 3'b000; s_rs1 = 1; s_rs2 = 2; s_imm = 32'h10;
        step();
        check("beq_upd_valid", 32'(upd_valid_o), 1);
        check("beq_upd_taken", 32'(upd_taken_o), 0);
        check("beq_redirect", 32'(redirect_o), 0);
        check("beq_branch_cnt", 32'(branch_cnt_o), 1);
        check("beq_mispred_cnt", 32'(mispred_cnt_o), 0);

        // mispredicted taken BLT
        push_rec(32'h200, 0, 0);
        set_idle(); s_exv = 1; s_f3 = 3'b100; s_rs1 = 32'hFFFF_FFFF; s_rs2 = 1; s_imm = 32'h40;
        step();
        check("blt_redirect", 32'(redirect_o), 1);
        check("blt_redirect_pc", redirect_pc_o, 32'h240);
        check("blt_flush", 32'(flush_o), 1);
        check("blt_mispred_cnt", 32'(mispred_cnt_o), 1);

        // JALR target mismatch
        push_rec(32'h300, 1, 32'h500);
        set_idle(); s_exv = 1; s_jump = 1; s_jalr = 1; s_rs1 = 32'h601; s_imm = 0;
        step();
        check("jalr_target", upd_target_o, 32'h600);
        check("jalr_redirect_pc", redirect_pc_o, 32'h600);
        check("jalr_redirect", 32'(redirect_o), 1);

        // fill past full, then resolve 8 across the pointer wrap
        for (int i = 0; i <= DEPTH; i++) begin
            push_rec(32'h1000 + 32'(4 * i), 0, 0);
            if (i == DEPTH - 1) check("full_ready", 32'(pred_ready_o), 0);
        end
        for (int i = 0; i < 8; i++) begin
            set_idle();
            s_exv = 1; s_f3 = 3'b001; s_rs1 = 7; s_rs2 = 7;
            s_pv = 1; s_ppc = 32'h2000 + 32'(4 * i);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            set_idle(); s_exv = 1; s_f3 = 3'b001; s_rs1 = 7; s_rs2 = 7;
            step();
        end

        // flush with a concurrent push
        for (int i = 0; i < 3; i++) push_rec(32'h3000 + 32'(4 * i), 0, 0);
        set_idle(); s_exv = 1; s_f3 = 3'b000; s_rs1 = 5; s_rs2 = 5; s_imm = 8;
        s_pv = 1; s_ppc = 32'h3100;
        step();
        check("flush_redirect_pc", redirect_pc_o, 32'h3008);
        set_idle(); s_exv = 1;
        step();
        check("flush_empty_err", 32'(fifo_err_o), 1);
        check("flush_empty_noupd", 32'(upd_valid_o), 0);

        // EX on empty FIFO
        set_idle(); s_exv = 1;
        step();
        check("empty_err", 32'(fifo_err_o), 1);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            set_idle();
            s_pv  = 1'($urandom_range(0, 1));
            s_ppc = {$urandom_range(0, 255), 2'b00};
            s_ptk = 1'($urandom_range(0, 1));
            s_ptg = {$urandom_range(0, 255), 2'b00};
            s_exv = ($urandom_range(0, 2) == 0);
            s_jump = ($urandom_range(0, 3) == 0);
            s_jalr = s_jump && $urandom_range(0, 1);
            s_f3  = 3'($urandom_range(0, 7));
            s_rs1 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            s_rs2 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            s_imm = {$urandom_range(0, 63), 2'b00};
            step();
        end

        // reset mid-stream with records queued
        push_rec(32'h4000, 0, 0);
        push_rec(32'h4004, 1, 32'h4100);
        set_idle(); s_exv = 1; s_f3 = 3'b000; s_rs1 = 1; s_rs2 = 1;
        step();
        @(negedge clk_i);
        pred_valid_i = 0; ex_valid_i = 0;
        #2;
        rst_ni = 0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clk_i);
        rst_ni = 1;
        set_idle(); s_exv = 1;
        step();
        check("post_reset_err", 32'(fifo_err_o), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
